wb_gain_multi: RTL

//  Next-generation white-balance gain stage for the raw data channel. Processes PIX_PER_CLK

---
 rtl/wb_gain_multi.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/wb_gain_multi.sv
// White-balance gain stage: PIX_PER_CLK lanes, Bayer colour derived from a per-frame pattern register.
// Optional macro WB_GAIN_ROUND_EN: round-half-up before the fractional shift (default truncates).
module wb_gain_multi #(
  parameter int unsigned SENSOR_DAT_WIDTH = 10,
  parameter int unsigned WB_GAIN_WIDTH    = 11,
  parameter int unsigned WB_RATIO         = 8,
  parameter int unsigned PIX_PER_CLK      = 2,
  parameter int unsigned REG_WD           = 32
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    i_fval,
  input  logic                                    i_lval,
  input  logic [SENSOR_DAT_WIDTH*PIX_PER_CLK-1:0] iv_pix_data,
  input  logic [1:0]                              iv_bayer_pattern,
  input  logic [REG_WD-1:0]                       iv_pixel_format,
  input  logic [2:0]                              iv_test_image_sel,
  input  logic [WB_GAIN_WIDTH-1:0]                iv_wb_gain_r,
  input  logic [WB_GAIN_WIDTH-1:0]                iv_wb_gain_g,
  input  logic [WB_GAIN_WIDTH-1:0]                iv_wb_gain_b,
  output logic                                    o_fval,
  output logic                                    o_lval,
  output logic [SENSOR_DAT_WIDTH*PIX_PER_CLK-1:0] ov_pix_data
);

  localparam int unsigned SW     = SENSOR_DAT_WIDTH;
  localparam int unsigned GW     = WB_GAIN_WIDTH;
  localparam int unsigned PW1    = SW + GW + 1;
  localparam int unsigned DW     = SW * PIX_PER_CLK;
  localparam int unsigned SAT_LO = SW + WB_RATIO;
  localparam logic [GW-1:0] UNITY = GW'(1) << WB_RATIO;
`ifdef WB_GAIN_ROUND_EN
  localparam logic [PW1-1:0] RND = PW1'(1) << (WB_RATIO - 1);
`else
  localparam logic [PW1-1:0] RND = '0;
`endif

  logic          armed, fval_q, lval_q, row_q, col_q;
  logic [GW-1:0] gain_r_l, gain_g_l, gain_b_l;
  logic [1:0]    pattern_l;
  logic          gain_en_l;
  logic [5:0]    fmt_key;
  logic          mono_c, fval_rise_c, lval_fall_c, row_cur;
  logic          unused_fmt;

  logic [GW-1:0]  coef_c    [PIX_PER_CLK];
  logic [SW-1:0]  pix_s1    [PIX_PER_CLK];
  logic [GW-1:0]  coef_s1   [PIX_PER_CLK];
  logic [PW1-1:0] prod_s2   [PIX_PER_CLK];
  logic [SW-1:0]  byp_s2    [PIX_PER_CLK];
  logic           fval_s1, lval_s1, en_s1, fval_s2, lval_s2, en_s2;
  logic [DW-1:0]  pix_out_c;

  assign fmt_key     = {iv_pixel_format[20], iv_pixel_format[19], iv_pixel_format[3:0]};
  assign mono_c      = (fmt_key == 6'b010001) || (fmt_key == 6'b100011);
  assign unused_fmt  = ^{iv_pixel_format[REG_WD-1:21], iv_pixel_format[18:4]};
  assign fval_rise_c = i_fval & ~fval_q;
  assign lval_fall_c = lval_q & ~i_lval;
  assign row_cur     = fval_rise_c ? 1'b0 : row_q;

  // Frame-level control: arming, per-frame register latch, row/column phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed     <= 1'b0;
      fval_q    <= 1'b0;
      lval_q    <= 1'b0;
      row_q     <= 1'b0;
      col_q     <= 1'b0;
      gain_r_l  <= UNITY;
      gain_g_l  <= UNITY;
      gain_b_l  <= UNITY;
      pattern_l <= 2'b00;
      gain_en_l <= 1'b0;
    end else begin
      fval_q <= i_fval;
      lval_q <= i_lval;
      if (!i_fval) begin
        armed     <= 1'b1;
        gain_r_l  <= iv_wb_gain_r;
        gain_g_l  <= iv_wb_gain_g;
        gain_b_l  <= iv_wb_gain_b;
        pattern_l <= iv_bayer_pattern;
        gain_en_l <= !mono_c && (iv_test_image_sel == 3'b000);
      end
      if (fval_rise_c)
        row_q <= 1'b0;
      else if (i_fval && lval_fall_c)
        row_q <= ~row_q;
      col_q <= i_lval ? ~col_q : 1'b0;
    end
  end

  // Green sits where row^col matches pattern[0]; red occupies the row equal to pattern[1].
  for (genvar k = 0; k < PIX_PER_CLK; k++) begin : g_lane
    logic lane_col, is_g, is_r, unused_lsb;
    assign lane_col   = (PIX_PER_CLK == 1) ? col_q : 1'(k % 2);
    assign is_g       = ((row_cur ^ lane_col) == pattern_l[0]);
    assign is_r       = (row_cur == pattern_l[1]);
    assign coef_c[k]  = is_g ? gain_g_l : (is_r ? gain_r_l : gain_b_l);
    assign unused_lsb = ^prod_s2[k][WB_RATIO-1:0];
    assign pix_out_c[k*SW +: SW] = !en_s2 ? byp_s2[k] :
                                   (|prod_s2[k][PW1-1:SAT_LO]) ? {SW{1'b1}} :
                                   prod_s2[k][SAT_LO-1:WB_RATIO];
  end

  // S1 capture and S2 multiply; multiplier only clocked inside lines.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fval_s1 <= 1'b0;
      lval_s1 <= 1'b0;
      en_s1   <= 1'b0;
      fval_s2 <= 1'b0;
      lval_s2 <= 1'b0;
      en_s2   <= 1'b0;
      for (int k = 0; k < int'(PIX_PER_CLK); k++) begin
        pix_s1[k]  <= '0;
        coef_s1[k] <= '0;
        prod_s2[k] <= '0;
        byp_s2[k]  <= '0;
      end
    end else begin
      fval_s1 <= i_fval & armed;
      lval_s1 <= i_lval & armed;
      en_s1   <= gain_en_l;
      fval_s2 <= fval_s1;
      lval_s2 <= lval_s1;
      en_s2   <= en_s1;
      for (int k = 0; k < int'(PIX_PER_CLK); k++) begin
        pix_s1[k]  <= iv_pix_data[k*SW +: SW];
        coef_s1[k] <= coef_c[k];
        byp_s2[k]  <= pix_s1[k];
        if (lval_s1)
          prod_s2[k] <= PW1'(pix_s1[k]) * PW1'(coef_s1[k]) + RND;
      end
    end
  end

  // S3 saturate/bypass and blanking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_fval      <= 1'b0;
      o_lval      <= 1'b0;
      ov_pix_data <= '0;
    end else begin
      o_fval      <= fval_s2;
      o_lval      <= fval_s2 & lval_s2;
      ov_pix_data <= (fval_s2 && lval_s2) ? pix_out_c : '0;
    end
  end

endmodule
